shift_mul: RTL and testbench

SHIFT_MUL -- requirements
Module: shift_mul

---
 rtl/shift_mul.sv | 126 ++++++++++++
 tb/tb_shift_mul.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_mul.sv
// shift_mul -- sequential unsigned shift-and-add multiplier.
//
// Computes p = a * b over BITS cycles of a three-state FSM
// (IDLE -> CALC -> DONE). One multiplier bit is consumed per CALC cycle.
// A new start may be accepted directly from DONE, which gives one result
// every BITS+1 cycles when enable is held high.
//
// Optional feature: define SHIFT_MUL_EARLY_EXIT_EN to leave CALC as soon
// as the remaining multiplier bits are all zero. The latency then becomes
// (index of the highest set bit of b)+1 CALC cycles, or 1 cycle for b=0.
// The product is the same either way.
//
// Ports:
//   clk    in   1        clock, rising edge
//   rst    in   1        synchronous active-high reset
//   enable in   1        start request, sampled in IDLE and DONE only
//   a      in   BITS     multiplicand, unsigned
//   b      in   BITS     multiplier, unsigned
//   p      out  2*BITS   product, registered, held until the next done
//   done   out  1        one-cycle pulse, p valid
//   busy   out  1        high while in CALC
module shift_mul #(
  parameter int BITS = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  output logic [2*BITS-1:0] p,
  output logic              done,
  output logic              busy
);

  localparam int PW = 2 * BITS;
  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [BITS-1:0] mplier;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   acc_sum;
  logic [BITS-1:0] mplier_shift;
  logic            last_step;

  // Next accumulator value and end-of-computation detection for one CALC step.
  always_comb begin
    acc_sum      = acc;
    mplier_shift = mplier >> 1;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end else begin
      acc_sum = acc;
    end
`ifdef SHIFT_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain, further steps cannot change acc.
    last_step = (cnt == LAST_CNT) || (mplier_shift == {BITS{1'b0}});
`else
    last_step = (cnt == LAST_CNT);
`endif
  end

  // FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= {PW{1'b0}};
      mcand  <= {PW{1'b0}};
      mplier <= {BITS{1'b0}};
      cnt    <= {CW{1'b0}};
      p      <= {PW{1'b0}};
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        // IDLE and DONE accept a start identically; DONE only ever lasts one cycle.
        IDLE, DONE: begin
          done <= 1'b0;
          if (enable) begin
            mcand  <= {{BITS{1'b0}}, a};
            mplier <= b;
            acc    <= {PW{1'b0}};
            cnt    <= {CW{1'b0}};
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_shift;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            // p is written only here, so it never shows partial sums.
            p     <= acc_sum;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mul.sv
// tb_shift_mul -- self-checking bench for shift_mul (BITS=48).
// Expected products and completion cycles are pushed to a scoreboard when an
// operation is started and popped by a monitor at every done pulse.
module tb_shift_mul;

  localparam int BITS = 48;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [BITS-1:0]   a;
  logic [BITS-1:0]   b;
  logic [2*BITS-1:0] p;
  logic              done;
  logic              busy;

  typedef struct {
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic [2*BITS-1:0] p;
    int                due;
  } exp_t;

  exp_t              sb[$];
  int                cyc = 0;
  int                checks = 0;
  int                passes = 0;
  logic              prev_done = 1'b0;
  logic [2*BITS-1:0] last_p = '0;

  shift_mul #(.BITS(BITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .a      (a),
    .b      (b),
    .p      (p),
    .done   (done),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected number of CALC cycles for a given multiplier.
  function automatic int exp_lat(input logic [BITS-1:0] bv);
    int lat;
    lat = BITS;
`ifdef SHIFT_MUL_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < BITS; i++) if (bv[i]) lat = i + 1;
`endif
    return lat;
  endfunction

  // Monitor: pop the scoreboard at each done pulse and compare.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      checks++;
      assert (busy === 1'b0) passes++;
      else $error("FAIL done_busy_overlap busy=%0b required 0", busy);
      checks++;
      assert (prev_done === 1'b0) passes++;
      else $error("FAIL done_width done high on consecutive cycles, required one-cycle pulse");
      if (sb.size() == 0) begin
        checks++;
        $error("FAIL unexpected_done p=%0h with no operation pending", p);
      end else begin
        e = sb.pop_front();
        checks++;
        assert (p === e.p) passes++;
        else $error("FAIL product a=%0d b=%0d observed p=%0h required %0h", e.a, e.b, p, e.p);
        checks++;
        assert (cyc === e.due) passes++;
        else $error("FAIL latency a=%0d b=%0d observed cycle %0d required %0d", e.a, e.b, cyc, e.due);
        last_p = e.p;
        $display("dump a=%0d b=%0d p=%0d", e.a, e.b, p);
      end
    end
    prev_done = done;
  end

  // Drive a start request at the current negedge and record the expectation.
  task automatic start_op(input logic [BITS-1:0] av, input logic [BITS-1:0] bv,
                          input logic [2*BITS-1:0] pexp);
    exp_t e;
    a      = av;
    b      = bv;
    enable = 1'b1;
    e.a    = av;
    e.b    = bv;
    e.p    = pexp;
    e.due  = cyc + 1 + exp_lat(bv);
    sb.push_back(e);
  endtask

  // Let the operation run, scrambling inputs during CALC; returns at the done negedge.
  task automatic run_calc(input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    if (!hold) enable = 1'b0;
    a = BITS'({$urandom, $urandom});
    b = BITS'({$urandom, $urandom});
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      $error("FAIL timeout no done within %0d cycles", n);
    end
  endtask

  initial begin
    logic [BITS-1:0] av;
    logic [BITS-1:0] bv;
    logic [BITS-1:0] maxv;

    rst    = 1'b1;
    enable = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);

    checks++;
    assert (p === '0 && done === 1'b0 && busy === 1'b0) passes++;
    else $error("FAIL reset_state p=%0h done=%0b busy=%0b required 0/0/0", p, done, busy);
    rst = 1'b0;

    // Basic product; the first edge with rst=0 samples enable.
    start_op(48'd3, 48'd5, 96'd15);
    run_calc(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    assert (p === 96'd15 && busy === 1'b0 && done === 1'b0) passes++;
    else $error("FAIL idle_hold p=%0h busy=%0b done=%0b required 15/0/0", p, busy, done);

    // Maximum operands.
    maxv = '1;
    start_op(maxv, maxv, 96'hFFFFFFFFFFFE000000000001);
    run_calc(1'b0);
    @(negedge clk);

    // Back-to-back with enable held high.
    start_op(48'd0, 48'd7, 96'd0);
    run_calc(1'b1);
    start_op(48'd7, 48'd0, 96'd0);
    run_calc(1'b1);
    start_op(48'd12345, 48'd678, 96'd8369910);
    run_calc(1'b0);
    @(negedge clk);

    // Early-exit latency case.
    start_op(48'd1000, 48'd1, 96'd1000);
    run_calc(1'b0);
    @(negedge clk);

    // Reset in the middle of CALC.
    start_op(48'd100, 48'd200, 96'd20000);
    @(negedge clk);
    enable = 1'b0;
    repeat (19) @(negedge clk);
`ifndef SHIFT_MUL_EARLY_EXIT_EN
    checks++;
    assert (p === last_p && busy === 1'b1) passes++;
    else $error("FAIL mid_calc_hold p=%0h busy=%0b required p=%0h busy=1", p, busy, last_p);
`endif
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    assert (p === '0 && done === 1'b0 && busy === 1'b0) passes++;
    else $error("FAIL mid_reset p=%0h done=%0b busy=%0b required 0/0/0", p, done, busy);
    rst = 1'b0;
    start_op(48'd9, 48'd9, 96'd81);
    run_calc(1'b0);
    @(negedge clk);

    // Randomized cross-check against a*b, mostly back-to-back.
    for (int i = 0; i < 1000; i++) begin
      av = BITS'({$urandom, $urandom});
      bv = BITS'({$urandom, $urandom}) >> $urandom_range(0, BITS - 1);
      if ($urandom_range(0, 15) == 0) bv = '0;
      if ($urandom_range(0, 15) == 0) av = '0;
      start_op(av, bv, {{BITS{1'b0}}, av} * {{BITS{1'b0}}, bv});
      run_calc(1'b1);
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        @(negedge clk);
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    assert (sb.size() == 0) passes++;
    else $error("FAIL scoreboard_drain observed %0d pending required 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
